// File: rtl/matmul_sequencer.sv
// Cell-by-cell matrix multiply scheduler: walks C in row-major order, accumulates
// A-row x B-column inner products, writes saturated results, then hands off to streaming.
module matmul_sequencer #(
  parameter int maxWidthLen = 4,
  parameter int sizeValue   = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          abort,
  input  logic [maxWidthLen-1:0]        lastI,
  input  logic [maxWidthLen-1:0]        lastJ,
  input  logic [maxWidthLen-1:0]        lastK,
  output logic [maxWidthLen-1:0]        aRow,
  output logic [maxWidthLen-1:0]        aCol,
  input  logic signed [sizeValue-1:0]   aData,
  output logic [maxWidthLen-1:0]        bRow,
  output logic [maxWidthLen-1:0]        bCol,
  input  logic signed [sizeValue-1:0]   bData,
  output logic                          cWe,
  output logic [maxWidthLen-1:0]        cRow,
  output logic [maxWidthLen-1:0]        cCol,
  output logic signed [sizeValue-1:0]   cData,
  output logic                          outRdy,
  output logic [maxWidthLen-1:0]        outSizeX,
  output logic [maxWidthLen-1:0]        outSizeY,
  input  logic                          outMRdy,
  output logic                          busy,
  output logic                          done
);

  localparam int AccW  = 2 * sizeValue + maxWidthLen;
  localparam int ProdW = 2 * sizeValue;

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_FETCH, S_MAC, S_WRITE, S_STREAM, S_WAIT
  } state_t;

  state_t                       state_q;
  logic [maxWidthLen-1:0]       i_q, j_q, k_q;
  logic [maxWidthLen-1:0]       last_i_q, last_j_q, last_k_q;
  logic signed [AccW-1:0]       acc_q;
  logic [maxWidthLen-1:0]       a_row_q, a_col_q, b_row_q, b_col_q;
  logic [maxWidthLen-1:0]       c_row_q, c_col_q, size_x_q, size_y_q;
  logic signed [sizeValue-1:0]  c_data_q;
  logic                         cwe_q, out_rdy_q, busy_q, done_q;

  logic signed [ProdW-1:0]      prod_d;
  logic signed [AccW-1:0]       acc_d;
  logic signed [sizeValue-1:0]  sat_d;

  assign prod_d = aData * bData;
  assign acc_d  = acc_q + {{maxWidthLen{prod_d[ProdW-1]}}, prod_d};

  // The result fits only when every bit above the target sign bit matches it.
  always_comb begin
    sat_d = acc_q[sizeValue-1:0];
    if (!(&acc_q[AccW-1:sizeValue-1]) && (|acc_q[AccW-1:sizeValue-1])) begin
      sat_d = acc_q[AccW-1] ? {1'b1, {(sizeValue-1){1'b0}}} : {1'b0, {(sizeValue-1){1'b1}}};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      i_q       <= '0;
      j_q       <= '0;
      k_q       <= '0;
      last_i_q  <= '0;
      last_j_q  <= '0;
      last_k_q  <= '0;
      acc_q     <= '0;
      a_row_q   <= '0;
      a_col_q   <= '0;
      b_row_q   <= '0;
      b_col_q   <= '0;
      c_row_q   <= '0;
      c_col_q   <= '0;
      c_data_q  <= '0;
      size_x_q  <= '0;
      size_y_q  <= '0;
      cwe_q     <= 1'b0;
      out_rdy_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      cwe_q     <= 1'b0;
      out_rdy_q <= 1'b0;
      done_q    <= 1'b0;
      if (abort && state_q != S_IDLE) begin
        state_q <= S_IDLE;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (start) begin
              last_i_q <= lastI;
              last_j_q <= lastJ;
              last_k_q <= lastK;
              size_x_q <= lastJ;
              size_y_q <= lastI;
              i_q      <= '0;
              j_q      <= '0;
              busy_q   <= 1'b1;
              state_q  <= S_CLEAR;
            end
          end
          // Addresses are presented while in FETCH so the synchronous memories
          // return the element pair during the following MAC cycle.
          S_CLEAR: begin
            acc_q   <= '0;
            k_q     <= '0;
            a_row_q <= i_q;
            a_col_q <= '0;
            b_row_q <= '0;
            b_col_q <= j_q;
            state_q <= S_FETCH;
          end
          S_FETCH: state_q <= S_MAC;
          S_MAC: begin
            acc_q <= acc_d;
            if (k_q == last_k_q) begin
              state_q <= S_WRITE;
            end else begin
              k_q     <= k_q + 1'b1;
              a_col_q <= k_q + 1'b1;
              b_row_q <= k_q + 1'b1;
              state_q <= S_FETCH;
            end
          end
          S_WRITE: begin
            cwe_q    <= 1'b1;
            c_row_q  <= i_q;
            c_col_q  <= j_q;
            c_data_q <= sat_d;
            if (j_q == last_j_q) begin
              j_q <= '0;
              i_q <= i_q + 1'b1;
            end else begin
              j_q <= j_q + 1'b1;
            end
            state_q <= (i_q == last_i_q && j_q == last_j_q) ? S_STREAM : S_CLEAR;
          end
          S_STREAM: begin
            out_rdy_q <= 1'b1;
            state_q   <= S_WAIT;
          end
          S_WAIT: begin
            if (outMRdy) begin
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= S_IDLE;
            end
          end
          default: begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign aRow     = a_row_q;
  assign aCol     = a_col_q;
  assign bRow     = b_row_q;
  assign bCol     = b_col_q;
  assign cWe      = cwe_q;
  assign cRow     = c_row_q;
  assign cCol     = c_col_q;
  assign cData    = c_data_q;
  assign outRdy   = out_rdy_q;
  assign outSizeX = size_x_q;
  assign outSizeY = size_y_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule
